// File: rtl/count_arb_pkg.sv
// Shared types and default sizing for the count_arbiter slice.
package count_arb_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/count_arbiter_rr_pick.sv
// Combinational round-robin search: first set request above ptr_i, with wrap.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  win_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(ptr_i) + k) % NREQ;
      if (!vld_o && req_i[j]) begin
        vld_o = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
    win_o = vld_o ? (NREQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/count_arbiter.sv
// Arbitrates NREQ requesters onto one dual-channel counter (En/Slt).
// COUNT_ARB_PRIO0_EN: requester 0 always wins when requesting; others round-robin.
module count_arbiter
  import count_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ-1:0]       ReqSlt,
  input  logic [NREQ*LEN_W-1:0] ReqLen,
  output logic [NREQ-1:0]       Gnt,
  output logic [NREQ-1:0]       Done,
  output logic                  CntEn,
  output logic                  CntSlt,
  output logic                  Busy
);
  localparam int IDX_W = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    win_q, win_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               slt_q, slt_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [NREQ-1:0]    gnt_q, gnt_d, done_q, done_d;
  logic               en_q, en_d, cslt_q, cslt_d, busy_q, busy_d;

  logic [NREQ-1:0]    rr_req, pick_oh, sel_oh;
  logic [IDX_W-1:0]   pick_idx, sel_idx;
  logic               pick_vld, sel_vld;
  logic [LEN_W-1:0]   sel_len;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req_i (rr_req),
    .ptr_i (ptr_q),
    .win_o (pick_oh),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

`ifdef COUNT_ARB_PRIO0_EN
  assign rr_req  = {Req[NREQ-1:1], 1'b0};
  assign sel_vld = Req[0] | pick_vld;
  assign sel_oh  = Req[0] ? NREQ'(1) : pick_oh;
  assign sel_idx = Req[0] ? '0 : pick_idx;
`else
  assign rr_req  = Req;
  assign sel_vld = pick_vld;
  assign sel_oh  = pick_oh;
  assign sel_idx = pick_idx;
`endif

  assign sel_len = ReqLen[int'(sel_idx)*LEN_W +: LEN_W];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      widx_q  <= '0;
      ptr_q   <= IDX_W'(NREQ-1);
      slt_q   <= 1'b0;
      rem_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      cslt_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      widx_q  <= widx_d;
      ptr_q   <= ptr_d;
      slt_q   <= slt_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      cslt_q  <= cslt_d;
      busy_q  <= busy_d;
    end
  end

  // Requester inputs are only looked at in IDLE; the burst runs on latched copies.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    widx_d  = widx_q;
    ptr_d   = ptr_q;
    slt_d   = slt_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: if (sel_vld) begin
        win_d   = sel_oh;
        widx_d  = sel_idx;
        slt_d   = |(ReqSlt & sel_oh);
        rem_d   = sel_len;
        state_d = (sel_len != '0) ? RUN : DONE;
      end
      RUN: begin
        if (rem_q <= LEN_W'(1)) state_d = DONE;
        if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
      end
      DONE: begin
        ptr_d   = widx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    en_d   = 1'b0;
    cslt_d = 1'b0;
    busy_d = (state_d != IDLE);
    if (state_d == RUN) begin
      gnt_d  = win_d;
      en_d   = 1'b1;
      cslt_d = slt_d;
    end
    if (state_d == DONE) done_d = win_d;
  end

  assign Gnt    = gnt_q;
  assign Done   = done_q;
  assign CntEn  = en_q;
  assign CntSlt = cslt_q;
  assign Busy   = busy_q;
endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// burst-schedule reference model.
module tb_count_arbiter;
  localparam int N = 4;
  localparam int L = 4;

  logic             Clk, Reset;
  logic [N-1:0]     Req, ReqSlt;
  logic [N*L-1:0]   ReqLen;
  logic [N-1:0]     Gnt, Done;
  logic             CntEn, CntSlt, Busy;

  count_arbiter #(.NREQ(N), .LEN_W(L)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqSlt(ReqSlt), .ReqLen(ReqLen),
    .Gnt(Gnt), .Done(Done), .CntEn(CntEn), .CntSlt(CntSlt), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         en;
    logic         slt;
    logic         busy;
  } exp_t;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t cur;
  exp_t sched[$];
  int   ptr;
  int   glog[$];
  logic [N-1:0] prev_gnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(logic [N-1:0] g, logic [N-1:0] d, logic e, logic s, logic b);
    exp_t x;
    x.gnt = g; x.done = d; x.en = e; x.slt = s; x.busy = b;
    return x;
  endfunction

  function automatic int pick(logic [N-1:0] req);
`ifdef COUNT_ARB_PRIO0_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Advance the model across one rising edge given the inputs it will see.
  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] slt,
                            input logic [N*L-1:0] len);
    if (sched.size() > 0) cur = sched.pop_front();
    else if (cur.busy) cur = mk('0, '0, 0, 0, 0);
    else if (req != '0) begin
      int w, n;
      logic [N-1:0] oh;
      w  = pick(req);
      n  = int'(len[w*L +: L]);
      oh = '0; oh[w] = 1'b1;
      for (int i = 0; i < n; i++) sched.push_back(mk(oh, '0, 1, slt[w], 1));
      sched.push_back(mk('0, oh, 0, 0, 1));
      ptr = w;
      cur = sched.pop_front();
    end else cur = mk('0, '0, 0, 0, 0);
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] slt,
                       input logic [N*L-1:0] len);
    @(negedge Clk);
    check("gnt", 32'(Gnt), 32'(cur.gnt));
    check("done", 32'(Done), 32'(cur.done));
    check("cnten", 32'(CntEn), 32'(cur.en));
    check("cntslt", 32'(CntSlt), 32'(cur.slt));
    check("busy", 32'(Busy), 32'(cur.busy));
    if (Gnt != '0 && prev_gnt == '0)
      for (int i = 0; i < N; i++) if (Gnt[i]) glog.push_back(i);
    prev_gnt = Gnt;
    Req = req; ReqSlt = slt; ReqLen = len;
    model_step(req, slt, len);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0);
  endtask

  task automatic check_order(input string tag, input int a, input int b, input int c, input int d);
    int want[4];
    want = '{a, b, c, d};
    for (int i = 0; i < 4; i++)
      check(tag, (i < glog.size()) ? 32'(glog[i]) : 32'd99, 32'(want[i]));
  endtask

  task automatic model_reset();
    sched.delete();
    cur = mk('0, '0, 0, 0, 0);
    ptr = N - 1;
    prev_gnt = '0;
  endtask

  task automatic reset_mid_cycle();
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("rst_gnt", 32'(Gnt), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_en", 32'(CntEn), 32'd0);
    check("rst_slt", 32'(CntSlt), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    model_reset();
    Req = '0; ReqSlt = '0; ReqLen = '0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; Req = '0; ReqSlt = '0; ReqLen = '0;
    model_reset();
    repeat (2) @(negedge Clk);
    check("por_gnt", 32'(Gnt), 32'd0);
    check("por_done", 32'(Done), 32'd0);
    check("por_en", 32'(CntEn), 32'd0);
    check("por_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;

    // All four requesting, length 1: rotation starts at requester 0.
    glog.delete();
    for (int i = 0; i < 13; i++) cycle(4'b1111, 4'b0000, {4'd1, 4'd1, 4'd1, 4'd1});
    idle(3);
    check_order("ord_all", 0, 1, 2, 3);

    // Requester 0, length 5, channel 0; held long enough to re-request.
    for (int i = 0; i < 8; i++) cycle(4'b0001, 4'b0000, {4'd0, 4'd0, 4'd0, 4'd5});
    idle(10);

    // Zero-length request goes straight to DONE.
    for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0000, {4'd0, 4'd0, 4'd0, 4'd0});
    idle(3);

    // Requester 1 drops Req early in a length-6, channel-1 burst.
    cycle(4'b0010, 4'b0010, {4'd0, 4'd0, 4'd6, 4'd0});
    cycle(4'b0010, 4'b0010, {4'd0, 4'd0, 4'd6, 4'd0});
    cycle(4'b0000, 4'b1111, {4'd3, 4'd3, 4'd3, 4'd3});
    idle(8);

    // Reset in the middle of a length-9 burst.
    for (int i = 0; i < 4; i++) cycle(4'b0100, 4'b0000, {4'd0, 4'd9, 4'd0, 4'd0});
    reset_mid_cycle();

    // Requesters 0 and 2 held with length 2.
    glog.delete();
    for (int i = 0; i < 17; i++) cycle(4'b0101, 4'b0000, {4'd2, 4'd2, 4'd2, 4'd2});
    idle(4);
`ifdef COUNT_ARB_PRIO0_EN
    check_order("ord_02", 0, 0, 0, 0);
`else
    check_order("ord_02", 0, 2, 0, 2);
`endif

    // Random traffic, including lengths up to the 4-bit maximum.
    for (int i = 0; i < 600; i++)
      cycle(N'($urandom_range(0, 15)), N'($urandom), (N*L)'($urandom));
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
